// File: rtl/alu_cmd_sequencer_if.sv
// Command / ALU / result bundle for alu_cmd_sequencer.
//   in_*   : command valid/ready input (mode, op, a, b)
//   alu_*  : registered operands to the external ALU, alu_f is its result
//   out_*  : result valid/ready output with divide-by-zero flag
//   count  : command FIFO occupancy
// slave  : the sequencer side
// master : the side that issues commands, hosts the ALU and consumes results
interface alu_cmd_sequencer_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;

    logic          alu_mode;
    logic [1:0]    alu_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_f;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_f;
    logic          out_err;

    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_mode, in_op, in_a, in_b, alu_f, out_ready,
        output in_ready, alu_mode, alu_op, alu_a, alu_b, out_valid, out_f, out_err, count
    );

    modport master (
        output in_valid, in_mode, in_op, in_a, in_b, alu_f, out_ready,
        input  in_ready, alu_mode, alu_op, alu_a, alu_b, out_valid, out_f, out_err, count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for an 8-bit combinational ALU.
// Commands arrive on a valid/ready input and are queued in a DEPTH-entry FIFO.
// The FSM pops one command into the alu_* registers, lets the ALU settle for a
// cycle, captures alu_f into out_f (forced to all ones on divide by zero) and
// holds it on a valid/ready output until accepted.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_cmd_sequencer_if.slave (command in, ALU drive/result, result out, count)
module alu_cmd_sequencer #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 3 + 2 * W;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, capture;
    logic [EW-1:0] head;

    logic          alu_mode_q;
    logic [1:0]    alu_op_q;
    logic [W-1:0]  alu_a_q, alu_b_q;
    logic [W-1:0]  out_f_q;
    logic          out_err_q;
    logic          div_zero;

    assign push = bus.in_valid & bus.in_ready;
    assign head = mem_q[rptr_q];

    // Judged on the operands currently on the ALU, i.e. the command in DRIVE.
    assign div_zero = alu_mode_q & (alu_op_q == 2'b10) & (alu_b_q == '0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                capture = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (bus.out_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {bus.in_mode, bus.in_op, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            alu_mode_q <= 1'b0;
            alu_op_q   <= 2'b00;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            out_f_q    <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q     <= rptr_q + PW'(1);
                alu_mode_q <= head[EW-1];
                alu_op_q   <= head[EW-2:EW-3];
                alu_a_q    <= head[2*W-1:W];
                alu_b_q    <= head[W-1:0];
            end
            if (capture) begin
                out_err_q <= div_zero;
                out_f_q   <= div_zero ? {W{1'b1}} : bus.alu_f;
            end
        end
    end

    assign bus.in_ready  = (count_q < Full);
    assign bus.count     = count_q;
    assign bus.alu_mode  = alu_mode_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_f     = out_f_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The ALU that sits beside the sequencer; divide by zero yields 0 here so
    // that the sequencer's all-ones override is visible.
    always_comb begin
        bus.alu_f = '0;
        if (bus.alu_mode) begin
            case (bus.alu_op)
                2'b00: bus.alu_f = bus.alu_a + bus.alu_b;
                2'b01: bus.alu_f = bus.alu_a - bus.alu_b;
                2'b10: bus.alu_f = (bus.alu_b == '0) ? '0 : bus.alu_a / bus.alu_b;
                default: bus.alu_f = bus.alu_a * bus.alu_b;
            endcase
        end else begin
            case (bus.alu_op)
                2'b00: bus.alu_f = bus.alu_a & bus.alu_b;
                2'b01: bus.alu_f = bus.alu_a | bus.alu_b;
                2'b10: bus.alu_f = bus.alu_a ^ bus.alu_b;
                default: bus.alu_f = ~bus.alu_a;
            endcase
        end
    end

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       held = 1'b0;
    logic [7:0] held_f;
    logic       held_err;
    int         n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {err, f} for one command, from plain integer arithmetic.
    function automatic logic [8:0] model(input logic m, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
        int ai, bi, r;
        logic err;
        ai = int'(a);
        bi = int'(b);
        r = 0;
        err = 1'b0;
        if (m) begin
            case (op)
                2'd0: r = (ai + bi) % 256;
                2'd1: r = (ai - bi + 256) % 256;
                2'd2: if (bi == 0) begin err = 1'b1; r = 255; end else r = ai / bi;
                default: r = (ai * bi) % 256;
            endcase
        end else begin
            case (op)
                2'd0: r = ai & bi;
                2'd1: r = ai | bi;
                2'd2: r = ai ^ bi;
                default: r = 255 - ai;
            endcase
        end
        return {err, r[7:0]};
    endfunction

    // Called at a falling edge with inputs set: records handshakes that the
    // next rising edge will complete, then advances one cycle.
    task automatic step();
        logic acc_in, acc_out;
        logic [8:0] e;
        if (held) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_f", bus.out_f, held_f);
            check("hold_err", bus.out_err, held_err);
        end
        acc_in  = bus.in_valid & bus.in_ready;
        acc_out = bus.out_valid & bus.out_ready;
        if (acc_out) begin
            got_q.push_back({bus.out_err, bus.out_f});
            check("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_f", bus.out_f, e[7:0]);
                check("res_err", bus.out_err, e[8]);
            end
        end
        if (acc_in) exp_q.push_back(model(bus.in_mode, bus.in_op, bus.in_a, bus.in_b));
        held     = bus.out_valid & ~bus.out_ready;
        held_f   = bus.out_f;
        held_err = bus.out_err;
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic m, input logic [1:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        logic done;
        done = 1'b0;
        bus.in_mode  = m;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            done = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        check("push_accepted", done, 1);
    endtask

    task automatic drain(output int steps);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        steps = 0;
        while (exp_q.size() != 0 && steps < 200) begin
            step();
            steps++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_count", bus.count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_alu", {bus.alu_mode, bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("rst_out", {bus.out_err, bus.out_f}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency of a single MUL 4*3
        bus.out_ready = 1'b1;
        bus.in_mode = 1'b1; bus.in_op = 2'b11; bus.in_a = 8'd4; bus.in_b = 8'd3;
        bus.in_valid = 1'b1;
        check("lat_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("lat_n_valid", bus.out_valid, 0);
        check("lat_n_count", bus.count, 1);
        step();
        check("lat_alu_mode", bus.alu_mode, 1);
        check("lat_alu_op", bus.alu_op, 3);
        check("lat_alu_a", bus.alu_a, 4);
        check("lat_alu_b", bus.alu_b, 3);
        check("lat_n1_valid", bus.out_valid, 0);
        check("lat_n1_count", bus.count, 0);
        step();
        check("lat_n2_valid", bus.out_valid, 1);
        check("lat_f", bus.out_f, 12);
        check("lat_err", bus.out_err, 0);
        step();
        check("lat_drop", bus.out_valid, 0);

        // Arithmetic wrap/truncate, in order
        got_q.delete();
        push_cmd(1'b1, 2'b11, 8'd20, 8'd20);
        push_cmd(1'b1, 2'b01, 8'd2, 8'd4);
        drain(n);
        check("arith_n", got_q.size(), 2);
        check("mul_trunc", got_q[0], 9'h090);
        check("sub_wrap", got_q[1], 9'h0FE);

        // Divide by zero and a normal divide
        got_q.delete();
        push_cmd(1'b1, 2'b10, 8'd7, 8'd0);
        push_cmd(1'b1, 2'b10, 8'd7, 8'd2);
        drain(n);
        check("div_n", got_q.size(), 2);
        check("div_zero", got_q[0], 9'h1FF);
        check("div_7_2", got_q[1], 9'h003);

        // Logic ops
        got_q.delete();
        for (int k = 0; k < 4; k++) push_cmd(1'b0, 2'(k), 8'h0F, 8'h3C);
        drain(n);
        check("logic_n", got_q.size(), 4);
        check("and", got_q[0], 9'h00C);
        check("or", got_q[1], 9'h03F);
        check("xor", got_q[2], 9'h033);
        check("not", got_q[3], 9'h0F0);

        // Back-pressure: 6 offered, 5 fit (1 held + 4 queued)
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_mode = 1'b1; bus.in_op = 2'b00; bus.in_a = 8'(k); bus.in_b = 8'd10;
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        check("full_in_ready", bus.in_ready, 0);
        check("full_count", bus.count, 4);
        check("full_valid", bus.out_valid, 1);
        check("full_accepted", exp_q.size(), 5);
        repeat (3) step();
        got_q.delete();
        drain(n);
        check("full_cycles", n, 9);
        check("full_in_ready_back", bus.in_ready, 1);
        check("full_n", got_q.size(), 5);
        for (int k = 0; k < 5; k++) check("full_order", got_q[k], 9'(k + 10));

        // Reset while holding a result with 3 queued
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_mode = 1'b0; bus.in_op = 2'b01; bus.in_a = 8'(k); bus.in_b = 8'h80;
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        check("mid_count", bus.count, 3);
        check("mid_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_alu_a", bus.alu_a, 0);
        check("mid_rst_out", {bus.out_err, bus.out_f}, 0);
        exp_q.delete();
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        got_q.delete();
        repeat (10) step();
        check("no_stale", got_q.size(), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_mode   = 1'($urandom);
            bus.in_op     = 2'($urandom);
            bus.in_a      = 8'($urandom);
            bus.in_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(n);
        step();
        step();
        check("rand_count", bus.count, 0);
        check("rand_idle", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
